// File: rtl/srl_fifo_occ.sv
// Shift-register FIFO with occupancy count, almost-full/empty flags, synchronous
// flush and an optional registered first-word-fall-through output stage.
module srl_fifo_occ #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned AF_THRESH  = DEPTH - 2,
   parameter int unsigned AE_THRESH  = 1,
   parameter int unsigned OUT_REG    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   if_num_data,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(AE_THRESH);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] srl_sig;
   logic [ADDR_WIDTH:0]              count;
   logic [ADDR_WIDTH:0]              count_nxt;
   logic [ADDR_WIDTH-1:0]            rd_addr;
   logic [DATA_WIDTH-1:0]            head;
   logic                             wr_acc;
   logic                             rd_acc;
   logic                             pop;

   assign if_full_n = (count != CNT_MAX);
   assign wr_acc    = if_write & if_write_ce & if_full_n;

   // Storage is deliberately left out of reset; only occupancy defines validity.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         srl_sig <= {srl_sig[DEPTH-2:0], if_din};
      end
   end

   always_comb begin
      rd_addr = '0;
      if (count != '0) begin
         rd_addr = ADDR_WIDTH'(count - 1'b1);
      end
   end

   assign head = srl_sig[rd_addr];

   always_comb begin
      count_nxt = count;
      if (wr_acc && !pop) begin
         count_nxt = count + 1'b1;
      end else if (!wr_acc && pop) begin
         count_nxt = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic                  out_vld;
      logic [DATA_WIDTH-1:0] out_data;

      assign rd_acc = if_read & if_read_ce & out_vld;
      // Refill whenever the output stage is empty or being consumed this cycle.
      assign pop    = (count != '0) & (~out_vld | rd_acc);

      always_ff @(posedge clk) begin
         if (reset) begin
            out_vld  <= 1'b0;
            out_data <= '0;
         end else if (flush) begin
            out_vld  <= 1'b0;
         end else if (pop) begin
            out_vld  <= 1'b1;
            out_data <= head;
         end else if (rd_acc) begin
            out_vld  <= 1'b0;
         end
      end

      assign if_empty_n  = out_vld;
      assign if_dout     = out_data;
      assign if_num_data = count + {{ADDR_WIDTH{1'b0}}, out_vld};
   end else begin : g_comb_out
      assign rd_acc      = if_read & if_read_ce & (count != '0);
      assign pop         = rd_acc;
      assign if_empty_n  = (count != '0);
      assign if_dout     = head;
      assign if_num_data = count;
   end

   assign almost_full  = (count >= AF_LVL);
   assign almost_empty = (if_num_data <= AE_LVL);

endmodule

// File: tb/tb_srl_fifo_occ.sv
// Bench for srl_fifo_occ: both output modes side by side against a queue model,
// with directed scenarios and a randomized phase.
module tb_srl_fifo_occ;

   localparam int DW = 8;
   localparam int D  = 16;
   localparam int AW = 4;
   localparam int AF = 14;
   localparam int AE = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          if_write_ce = 1'b1;
   logic          if_write = 1'b0;
   logic [DW-1:0] if_din = '0;
   logic          if_read_ce = 1'b1;
   logic          if_read = 1'b0;

   logic          full_n0, empty_n0, af0, ae0;
   logic [DW-1:0] dout0;
   logic [AW:0]   num0;
   logic          full_n1, empty_n1, af1, ae1;
   logic [DW-1:0] dout1;
   logic [AW:0]   num1;

   srl_fifo_occ #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .AF_THRESH(AF),
                  .AE_THRESH(AE), .OUT_REG(0)) u0 (
      .clk(clk), .reset(reset), .flush(flush),
      .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(full_n0),
      .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(dout0), .if_empty_n(empty_n0),
      .if_num_data(num0), .almost_full(af0), .almost_empty(ae0));

   srl_fifo_occ #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .AF_THRESH(AF),
                  .AE_THRESH(AE), .OUT_REG(1)) u1 (
      .clk(clk), .reset(reset), .flush(flush),
      .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(full_n1),
      .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(dout1), .if_empty_n(empty_n1),
      .if_num_data(num1), .almost_full(af1), .almost_empty(ae1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: q0 holds the whole FIFO for the combinational mode; q1 holds the
   // storage part for the registered mode, with mv/md as the output stage.
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   bit            mv = 1'b0;
   logic [DW-1:0] md = '0;

   always @(posedge clk) begin : model
      bit w0, r0, w1, r1, p1;
      if (reset) begin
         q0.delete(); q1.delete(); mv = 1'b0; md = '0;
      end else if (flush) begin
         q0.delete(); q1.delete(); mv = 1'b0;
      end else begin
         w0 = if_write && if_write_ce && (q0.size() < D);
         r0 = if_read && if_read_ce && (q0.size() > 0);
         if (r0) void'(q0.pop_front());
         if (w0) q0.push_back(if_din);
         w1 = if_write && if_write_ce && (q1.size() < D);
         r1 = if_read && if_read_ce && mv;
         p1 = (q1.size() > 0) && (!mv || r1);
         if (p1) begin
            md = q1.pop_front();
            mv = 1'b1;
         end else if (r1) begin
            mv = 1'b0;
         end
         if (w1) q1.push_back(if_din);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m0_full_n",  full_n0,  q0.size() != D);
         check("m0_empty_n", empty_n0, q0.size() != 0);
         check("m0_num",     num0,     q0.size());
         check("m0_af",      af0,      q0.size() >= AF);
         check("m0_ae",      ae0,      q0.size() <= AE);
         if (q0.size() > 0) check("m0_dout", dout0, q0[0]);
         check("m1_full_n",  full_n1,  q1.size() != D);
         check("m1_empty_n", empty_n1, mv);
         check("m1_num",     num1,     q1.size() + int'(mv));
         check("m1_af",      af1,      q1.size() >= AF);
         check("m1_ae",      ae1,      (q1.size() + int'(mv)) <= AE);
         check("m1_dout",    dout1,    md);
      end
   end

   task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit fl, input bit rs);
      if_write = w;
      if_din   = d;
      if_read  = r;
      flush    = fl;
      reset    = rs;
      @(negedge clk);
   endtask

   initial begin
      int wp;
      logic [DW-1:0] exp_head;

      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk_en = 1'b1;
      check("rst_full_n0", full_n0, 1);
      check("rst_empty_n0", empty_n0, 0);
      check("rst_num0", num0, 0);
      check("rst_af0", af0, 0);
      check("rst_ae0", ae0, 1);
      check("rst_dout1", dout1, 0);
      check("rst_empty_n1", empty_n1, 0);

      // Fill to full, overfill, then drain in order.
      for (int k = 1; k <= D; k++) begin
         step(1'b1, DW'(k - 1), 1'b0, 1'b0, 1'b0);
         check("fill_num0", num0, k);
         check("fill_af0", af0, k >= 14);
         check("fill_ae0", ae0, k <= 1);
         check("fill_full_n0", full_n0, k != 16);
      end
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      check("over_num0", num0, 16);
      check("over_num1", num1, 17);
      check("over_full_n1", full_n1, 0);
      check("drain_start_dout1", dout1, 0);
      for (int i = 0; i < D; i++) begin
         check("drain_dout0", dout0, i);
         step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      check("drain_empty_n0", empty_n0, 0);
      check("drain_last_dout1", dout1, 8'hAA);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("drain_empty_n1", empty_n1, 0);

      // Single word latency through the registered stage.
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      check("lat_empty_n0", empty_n0, 1);
      check("lat_empty_n1_early", empty_n1, 0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("lat_empty_n1", empty_n1, 1);
      check("lat_dout1", dout1, 8'h3C);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Streaming at occupancy 5.
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, DW'(10 + i), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) begin
         step(1'b1, DW'(20 + c), 1'b1, 1'b0, 1'b0);
         exp_head = (c + 1 < 5) ? DW'(10 + c + 1) : DW'(20 + c + 1 - 5);
         check("stream_num0", num0, 5);
         check("stream_num1", num1, 5);
         check("stream_dout0", dout0, exp_head);
         check("stream_dout1", dout1, exp_head);
      end

      // Full with concurrent read and write: write must be refused.
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < D; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
      check("fullrw_num0", num0, 15);
      check("fullrw_full_n0", full_n0, 1);
      check("fullrw_dout0", dout0, 8'h41);
      for (int i = 0; i < D + 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Flush, then reset, at occupancy 9 with a write pending.
      for (int m = 0; m < 2; m++) begin
         step(1'b0, '0, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < 9; i++) step(1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
         check("clr_pre_num0", num0, 9);
         step(1'b1, 8'h77, 1'b0, m == 0, m == 1);
         check("clr_num0", num0, 0);
         check("clr_empty_n0", empty_n0, 0);
         check("clr_full_n0", full_n0, 1);
         check("clr_num1", num1, 0);
         check("clr_empty_n1", empty_n1, 0);
         step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
         step(1'b0, '0, 1'b0, 1'b0, 1'b0);
         check("clr_dout0", dout0, 8'h55);
         check("clr_dout1", dout1, 8'h55);
         check("clr_empty_n1_after", empty_n1, 1);
         step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end

      // Randomized traffic with alternating fill/drain bias.
      for (int n = 0; n < 4000; n++) begin
         wp = ((n / 250) % 2 == 1) ? 30 : 80;
         if_write_ce = ($urandom_range(7) != 0);
         if_read_ce  = ($urandom_range(7) != 0);
         step($urandom_range(99) < wp, DW'($urandom), $urandom_range(99) < (110 - wp),
              $urandom_range(96) == 0, $urandom_range(300) == 0);
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
